// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller.
// Holds the state, opcode, funct, ALUOp/ALUControl and datapath select codes.
// Purely declarative; no logic.
package mips_ctrl_pkg;

  localparam int OPCODE_W  = 6;
  localparam int FUNCT_W   = 6;
  localparam int ALUCTRL_W = 3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  // Opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (Instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUOp from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl codes
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  // ALU B operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_main_control_fsm_if.sv
// Controller <-> datapath bundle: instruction fields in, mux selects/enables out.
// No latency of its own; plain wires.
// No backpressure; the controller owns the master side.
interface mips_main_control_fsm_if #(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
);
  logic [OPCODE_W-1:0]  Op;
  logic [FUNCT_W-1:0]   Funct;
  logic                 IorD;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegDst;
  logic                 MemtoReg;
  logic                 RegWrite;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [1:0]           PCSrc;
  logic                 PCWrite;
  logic                 Branch;
  logic                 IllegalOp;

  modport master (
    input  Op, Funct,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCWrite, Branch, IllegalOp
  );

  modport slave (
    output Op, Funct,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCWrite, Branch, IllegalOp
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// ALU decoder: (ALUOp, Funct) -> ALUControl.
// Combinational, zero latency.
// No backpressure.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           alu_op_i,
  input  logic [FUNCT_W-1:0]   funct_i,
  output logic [ALUCTRL_W-1:0] alu_control_o
);

  // Fixed add/sub for address and compare; R-type defers to funct, unknown funct adds.
  always_comb begin
    alu_control_o = ALUCTL_ADD;
    case (alu_op_i)
      ALUOP_SUB:   alu_control_o = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALUCTL_ADD;
          FN_SUB:  alu_control_o = ALUCTL_SUB;
          FN_AND:  alu_control_o = ALUCTL_AND;
          FN_OR:   alu_control_o = ALUCTL_OR;
          FN_SLT:  alu_control_o = ALUCTL_SLT;
          default: alu_control_o = ALUCTL_ADD;
        endcase
      end
      default:     alu_control_o = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main controller (Moore FSM + ALU decoder); optional MAIN_CTRL_ILLEGAL_TRAP_EN traps unknown opcodes.
// Outputs decode from state only; lw 5 cycles, sw/R/addi 4, beq/j 3, unknown op 2 (or trap).
// No backpressure; reset forces all write enables low and the FSM to FETCH.
module mips_main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_main_control_fsm_if.master   bus
);

  state_e               state_q, state_d;
  state_e               dec_state;
  logic [OPCODE_W-1:0]  op;
  logic [1:0]           alu_op;
  logic [ALUCTRL_W-1:0] alu_ctl;
  logic                 iord, mem_write, ir_write, reg_dst, memto_reg, reg_write;
  logic                 alu_src_a, pc_write, branch;
  logic [1:0]           alu_src_b, pc_src;

  assign op = bus.Op;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state; the IR holds Op stable from DECODE through MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // While in reset, non-enable outputs show their FETCH values.
  assign dec_state = reset ? S_FETCH : state_q;

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    iord      = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_dst   = 1'b0;
    memto_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    alu_op    = ALUOP_ADD;
    pc_src    = PCSRC_ALURES;
    pc_write  = 1'b0;
    branch    = 1'b0;
    case (dec_state)
      S_FETCH:    begin ir_write = 1'b1; alu_src_b = SRCB_FOUR; pc_write = 1'b1; end
      S_DECODE:   alu_src_b = SRCB_IMM_SH;
      S_MEMADR:   begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
      S_MEMRD:    iord = 1'b1;
      S_MEMWB:    begin reg_write = 1'b1; memto_reg = 1'b1; end
      S_MEMWR:    begin iord = 1'b1; mem_write = 1'b1; end
      S_EXECUTE:  begin alu_src_a = 1'b1; alu_op = ALUOP_FUNCT; end
      S_ALUWB:    begin reg_dst = 1'b1; reg_write = 1'b1; end
      S_BRANCH:   begin alu_src_a = 1'b1; alu_op = ALUOP_SUB; pc_src = PCSRC_ALUOUT; branch = 1'b1; end
      S_ADDIEXEC: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
      S_ADDIWB:   reg_write = 1'b1;
      S_JUMP:     begin pc_src = PCSRC_JUMP; pc_write = 1'b1; end
      default:    ;
    endcase
  end

  mips_alu_decoder #(
    .FUNCT_W   (FUNCT_W),
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_dec (
    .alu_op_i      (alu_op),
    .funct_i       (bus.Funct),
    .alu_control_o (alu_ctl)
  );

  assign bus.IorD       = iord;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = memto_reg;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.PCSrc      = pc_src;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.Branch     = branch    & ~reset;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  assign bus.IllegalOp  = (state_q == S_TRAP) & ~reset;
`else
  assign bus.IllegalOp  = 1'b0;
`endif

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Directed bench for mips_main_control_fsm: walks every instruction class,
// reset mid-instruction and the unknown-opcode path, comparing all outputs
// each cycle against hand-computed per-state vectors.
module tb_mips_main_control_fsm;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mips_main_control_fsm_if ifc ();

  mips_main_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCWrite,Branch,IllegalOp}
  logic [16:0] obs;
  assign obs = {ifc.IorD, ifc.MemWrite, ifc.IRWrite, ifc.RegDst, ifc.MemtoReg,
                ifc.RegWrite, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUControl,
                ifc.PCSrc, ifc.PCWrite, ifc.Branch, ifc.IllegalOp};

  localparam logic [16:0] V_RESET    = {7'b0000000, 2'b01, 3'b010, 2'b00, 3'b000};
  localparam logic [16:0] V_FETCH    = {7'b0010000, 2'b01, 3'b010, 2'b00, 3'b100};
  localparam logic [16:0] V_DECODE   = {7'b0000000, 2'b11, 3'b010, 2'b00, 3'b000};
  localparam logic [16:0] V_MEMADR   = {7'b0000001, 2'b10, 3'b010, 2'b00, 3'b000};
  localparam logic [16:0] V_MEMRD    = {7'b1000000, 2'b00, 3'b010, 2'b00, 3'b000};
  localparam logic [16:0] V_MEMWB    = {7'b0000110, 2'b00, 3'b010, 2'b00, 3'b000};
  localparam logic [16:0] V_MEMWR    = {7'b1100000, 2'b00, 3'b010, 2'b00, 3'b000};
  localparam logic [16:0] V_EXE_SLT  = {7'b0000001, 2'b00, 3'b111, 2'b00, 3'b000};
  localparam logic [16:0] V_EXE_AND  = {7'b0000001, 2'b00, 3'b000, 2'b00, 3'b000};
  localparam logic [16:0] V_ALUWB    = {7'b0001010, 2'b00, 3'b010, 2'b00, 3'b000};
  localparam logic [16:0] V_BRANCH   = {7'b0000001, 2'b00, 3'b110, 2'b01, 3'b010};
  localparam logic [16:0] V_ADDIEXEC = {7'b0000001, 2'b10, 3'b010, 2'b00, 3'b000};
  localparam logic [16:0] V_ADDIWB   = {7'b0000010, 2'b00, 3'b010, 2'b00, 3'b000};
  localparam logic [16:0] V_JUMP     = {7'b0000000, 2'b00, 3'b010, 2'b10, 3'b100};
  localparam logic [16:0] V_TRAP     = {7'b0000000, 2'b00, 3'b010, 2'b00, 3'b001};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Safety net: the bench never waits on DUT events, but bound the run anyway.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    ifc.Op    = 6'b000000;
    ifc.Funct = 6'b000000;

    // Two cycles of reset: enables held low, other outputs at FETCH values.
    step(); chk("reset_c1", V_RESET);
    step(); chk("reset_c2", V_RESET);
    reset = 1'b0;
    #1 chk("post_reset_fetch", V_FETCH);

    // lw: FETCH DECODE MEMADR MEMRD MEMWB, FETCH again on cycle 6
    ifc.Op = 6'b100011;
    step(); chk("lw_decode", V_DECODE);
    step(); chk("lw_memadr", V_MEMADR);
    step(); chk("lw_memrd", V_MEMRD);
    step(); chk("lw_memwb", V_MEMWB);
    step(); chk("lw_fetch6", V_FETCH);

    // beq: BRANCH on cycle 3
    ifc.Op = 6'b000100;
    step(); chk("beq_decode", V_DECODE);
    step(); chk("beq_branch", V_BRANCH);
    step(); chk("beq_fetch", V_FETCH);

    // R-type slt
    ifc.Op = 6'b000000; ifc.Funct = 6'b101010;
    step(); chk("slt_decode", V_DECODE);
    step(); chk("slt_execute", V_EXE_SLT);
    step(); chk("slt_aluwb", V_ALUWB);
    step(); chk("slt_fetch", V_FETCH);

    // R-type and
    ifc.Funct = 6'b100100;
    step(); chk("and_decode", V_DECODE);
    step(); chk("and_execute", V_EXE_AND);
    step(); chk("and_aluwb", V_ALUWB);
    step(); chk("and_fetch", V_FETCH);

    // addi
    ifc.Op = 6'b001000; ifc.Funct = 6'b000000;
    step(); chk("addi_decode", V_DECODE);
    step(); chk("addi_exec", V_ADDIEXEC);
    step(); chk("addi_wb", V_ADDIWB);
    step(); chk("addi_fetch", V_FETCH);

    // j
    ifc.Op = 6'b000010;
    step(); chk("j_decode", V_DECODE);
    step(); chk("j_jump", V_JUMP);
    step(); chk("j_fetch", V_FETCH);

    // sw: MemWrite only in MEMWR
    ifc.Op = 6'b101011;
    step(); chk("sw_decode", V_DECODE);
    step(); chk("sw_memadr", V_MEMADR);
    step(); chk("sw_memwr", V_MEMWR);
    step(); chk("sw_fetch", V_FETCH);

    // Unrecognised opcode
    ifc.Op = 6'b111111;
    step(); chk("ill_decode", V_DECODE);
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    step(); chk("ill_trap", V_TRAP);
    for (int i = 0; i < 10; i++) begin
      step(); chk("ill_trap_hold", V_TRAP);
    end
    reset = 1'b1;
    #1 chk("ill_trap_reset", V_RESET);
    step();
    reset = 1'b0;
    #1 chk("ill_trap_cleared", V_FETCH);
`else
    step(); chk("ill_fetch3", V_FETCH);
`endif

    // Reset asserted in MEMRD aborts the load: no MEMWB write.
    ifc.Op = 6'b100011;
    step(); chk("rst_lw_decode", V_DECODE);
    step(); chk("rst_lw_memadr", V_MEMADR);
    step(); chk("rst_lw_memrd", V_MEMRD);
    reset = 1'b1;
    #1 chk("rst_in_memrd", V_RESET);
    step(); chk("rst_held", V_RESET);
    reset = 1'b0;
    #1 chk("rst_back_fetch", V_FETCH);
    step(); chk("rst_then_decode", V_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
